// File: rtl/sd_scan_pkg.sv
// Shared definitions for the SD block scan controller.
package sd_scan_pkg;

  localparam int BLK_BYTES = 512;
  localparam int PTR_W     = $clog2(BLK_BYTES);

  localparam logic [PTR_W-1:0] LAST_IDX        = PTR_W'(BLK_BYTES - 1);
  localparam logic [23:0]      TIMEOUT_DEFAULT = 24'd5_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/sd_scan_if.sv
// Bus bundle between the scan controller, the SD block reader and the byte consumer.
interface sd_scan_if;
  import sd_scan_pkg::*;

  logic             rd_req;
  logic [31:0]      rd_addr;
  logic [7:0]       sd_dout;
  logic             sd_valid;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic [PTR_W-1:0] byte_idx;

  modport master (
    output rd_req, rd_addr, byte_out, byte_valid, byte_idx,
    input  sd_dout, sd_valid, byte_ready
  );

  modport slave (
    input  rd_req, rd_addr, byte_out, byte_valid, byte_idx,
    output sd_dout, sd_valid, byte_ready
  );

endinterface

// File: rtl/sd_scan_sram.sv
// One-block staging buffer: single port, synchronous read with one cycle of latency.
module sram
  import sd_scan_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout
);

  logic [7:0] mem [BLK_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/sd_scan_ctrl.sv
// Reads consecutive SD blocks into a staging buffer and streams each block out byte by byte.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   REQ   | one-cycle read request for rd_addr
//   FILL  | capturing 512 bytes from the SD controller, gap timer running
//   DRAIN | streaming the buffer to the consumer
//   FIN   | one-cycle done pulse
module sd_scan_ctrl
  import sd_scan_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_finished,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] start_blk,
  input  logic [15:0] max_blks,
  sd_scan_if.master   bus,
  output logic [15:0] blk_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t           state, state_next;
  logic             rd_req;
  logic [31:0]      rd_addr_r;
  logic [PTR_W-1:0] fill_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] buf_addr;
  logic [23:0]      timer;
  logic [15:0]      max_blks_r;
  logic             stop_lat;
  logic             byte_valid_r;
  logic [7:0]       buf_dout;
  logic             buf_we;
  logic             accept, xfer, last_xfer, fill_last, timeout, blk_limit, stop_seen;

  assign accept    = (state == ST_IDLE) && start && init_finished;
  assign xfer      = (state == ST_DRAIN) && byte_valid_r && bus.byte_ready;
  assign last_xfer = xfer && (rd_ptr == LAST_IDX);
  assign fill_last = (state == ST_FILL) && bus.sd_valid && (fill_cnt == LAST_IDX);
  assign timeout   = (state == ST_FILL) && !bus.sd_valid && (timer <= 24'd1);
  assign blk_limit = (max_blks_r != 16'd0) && ((blk_count + 16'd1) == max_blks_r);
  assign stop_seen = stop_lat || stop;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_next = ST_REQ;
      end
      ST_REQ: begin
        rd_req     = 1'b1;
        state_next = ST_FILL;
      end
      ST_FILL: begin
        if (timeout)        state_next = ST_FIN;
        else if (fill_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_xfer) state_next = (stop_seen || blk_limit) ? ST_FIN : ST_REQ;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_addr_r    <= '0;
      fill_cnt     <= '0;
      rd_ptr       <= '0;
      timer        <= '0;
      max_blks_r   <= '0;
      blk_count    <= '0;
      stop_lat     <= 1'b0;
      byte_valid_r <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        rd_addr_r  <= start_blk;
        max_blks_r <= max_blks;
        blk_count  <= '0;
        err        <= 1'b0;
      end

      if (state_next == ST_IDLE) stop_lat <= 1'b0;
      else if (busy && stop)     stop_lat <= 1'b1;

      case (state)
        ST_REQ: begin
          fill_cnt <= '0;
          rd_ptr   <= '0;
          timer    <= TIMEOUT - 24'd1;
        end
        ST_FILL: begin
          if (bus.sd_valid) begin
            fill_cnt <= fill_cnt + 9'd1;
            timer    <= TIMEOUT - 24'd1;
          end else begin
            timer <= timer - 24'd1;
          end
          if (timeout) err <= 1'b1;
        end
        ST_DRAIN: begin
          // First DRAIN cycle only primes the buffer read; data appears the cycle after.
          if (!byte_valid_r) begin
            byte_valid_r <= 1'b1;
          end else if (bus.byte_ready) begin
            rd_ptr <= rd_ptr + 9'd1;
            if (rd_ptr == LAST_IDX) begin
              byte_valid_r <= 1'b0;
              if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
              if (state_next == ST_REQ) rd_addr_r <= rd_addr_r + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read one ahead on a transfer so consecutive bytes come out every cycle.
  always_comb begin
    buf_addr = rd_ptr;
    if (state == ST_FILL) buf_addr = fill_cnt;
    else if (xfer)        buf_addr = rd_ptr + 9'd1;
  end

  assign buf_we = (state == ST_FILL) && bus.sd_valid;

  sram u_buf (
    .clk  (clk),
    .we   (buf_we),
    .addr (buf_addr),
    .din  (bus.sd_dout),
    .dout (buf_dout)
  );

  assign bus.rd_req     = rd_req;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_idx   = rd_ptr;
  assign bus.byte_out   = byte_valid_r ? buf_dout : 8'h00;

endmodule

// File: tb/tb_sd_scan_ctrl.sv
// Randomized bench for sd_scan_ctrl: SD block responder, consumer with random stalls, expected-stream model.
module tb_sd_scan_ctrl;
  import sd_scan_pkg::*;

  localparam logic [23:0] TMO = 24'd1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_finished = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_blk = '0;
  logic [15:0] max_blks = '0;
  logic [15:0] blk_count;
  logic        busy, done, err;

  sd_scan_if bus ();

  sd_scan_ctrl #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .init_finished (init_finished),
    .start         (start),
    .stop          (stop),
    .start_blk     (start_blk),
    .max_blks      (max_blks),
    .bus           (bus),
    .blk_count     (blk_count),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] rd_log[$];
  int          blk_ptr = 0, exp_idx = 0, n_bytes = 0, done_cnt = 0;
  int          done_cyc = 0, last_xfer_cyc = 0, last_valid_cyc = 0, last512_cyc = 0;
  int          sd_limit = 512, gap_pct = 25, ready_pct = 0;
  logic        noise = 1'b0;
  logic [7:0]  seed = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sd_byte(input logic [31:0] a, input int i, input logic [7:0] s);
    logic [31:0] sum;
    sum = a + 32'(i);
    return sum[7:0] ^ s;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 32'hDEAD_BEEF;
  endfunction

  // SD controller model: answers each rd_req with 512 bytes (or sd_limit) and random gaps.
  logic [31:0] feed_addr;
  int          feed_i;
  initial begin
    bus.sd_valid = 1'b0;
    bus.sd_dout  = 8'h00;
    forever begin
      @(negedge clk);
      bus.sd_valid = 1'b0;
      if (reset_n && bus.rd_req) begin
        feed_addr = bus.rd_addr;
        rd_log.push_back(feed_addr);
        feed_i = 0;
        @(negedge clk);
        check("rd_req_width", 32'(bus.rd_req), 32'd0);
        while (feed_i < sd_limit && reset_n) begin
          bus.sd_valid = 1'b0;
          if ($urandom_range(99) >= gap_pct) begin
            bus.sd_valid   = 1'b1;
            bus.sd_dout    = sd_byte(feed_addr, feed_i, seed);
            last_valid_cyc = cyc;
            if (feed_i == BLK_BYTES - 1) last512_cyc = cyc;
            feed_i++;
          end
          if (feed_i < sd_limit) @(negedge clk);
        end
      end else if (noise) begin
        bus.sd_valid = 1'($urandom_range(1));
        bus.sd_dout  = 8'($urandom);
      end
    end
  end

  // Consumer: random stalls, hold checks, in-order byte checks against the model.
  logic       prev_valid = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_out = '0;
  logic [8:0] prev_idx = '0;
  initial begin
    bus.byte_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.byte_ready = ($urandom_range(99) >= ready_pct);
      if (!reset_n) begin
        exp_idx    = 0;
        blk_ptr    = rd_log.size();
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_stall) begin
          check("hold_valid", 32'(bus.byte_valid), 32'd1);
          check("hold_byte", 32'(bus.byte_out), 32'(prev_out));
          check("hold_idx", 32'(bus.byte_idx), 32'(prev_idx));
        end
        if (bus.byte_valid && !prev_valid)
          check("first_valid_latency", 32'(cyc - last512_cyc), 32'd2);
        if (bus.byte_valid && bus.byte_ready) begin
          if (blk_ptr < rd_log.size()) begin
            check("byte_idx", 32'(bus.byte_idx), 32'(exp_idx));
            check("byte_out", 32'(bus.byte_out), 32'(sd_byte(rd_log[blk_ptr], exp_idx, seed)));
          end else begin
            check("byte_without_request", 32'(rd_log.size()), 32'(blk_ptr + 1));
          end
          n_bytes++;
          last_xfer_cyc = cyc;
          exp_idx++;
          if (exp_idx == BLK_BYTES) begin
            exp_idx = 0;
            blk_ptr++;
          end
        end
        prev_valid = bus.byte_valid;
        prev_stall = bus.byte_valid && !bus.byte_ready;
        prev_out   = bus.byte_out;
        prev_idx   = bus.byte_idx;
      end
    end
  end

  task automatic new_run(input int rdy_pct, input logic [7:0] s, input logic nz);
    rd_log.delete();
    blk_ptr   = 0;
    exp_idx   = 0;
    n_bytes   = 0;
    done_cnt  = 0;
    sd_limit  = BLK_BYTES;
    ready_pct = rdy_pct;
    seed      = s;
    noise     = nz;
  endtask

  task automatic do_start(input logic [31:0] blk, input logic [15:0] mx);
    start_blk = blk;
    max_blks  = mx;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_req"}, 32'(bus.rd_req), 32'd0);
    check({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rd_addr"}, bus.rd_addr, 32'd0);
    check({tag, "_byte_out"}, 32'(bus.byte_out), 32'd0);
    check({tag, "_byte_idx"}, 32'(bus.byte_idx), 32'd0);
    check({tag, "_blk_count"}, 32'(blk_count), 32'd0);
  endtask

  logic [31:0] blk, blk2;
  int          mx, n;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n       = 1'b1;
    init_finished = 1'b1;
    @(negedge clk);

    // Two blocks, consumer always ready, data = (addr+i)[7:0]
    new_run(0, 8'h00, 1'b0);
    do_start(32'h0000_2000, 16'd2);
    wait_done("s1", 6000);
    check("s1_nreq", 32'(rd_log.size()), 32'd2);
    check("s1_addr0", log_at(0), 32'h0000_2000);
    check("s1_addr1", log_at(1), 32'h0000_2001);
    check("s1_bytes", 32'(n_bytes), 32'd1024);
    check("s1_blk_count", 32'(blk_count), 32'd2);
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_err", 32'(err), 32'd0);
    check("s1_fin_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));

    // Random stalls (30% not ready), random data and out-of-FILL noise on sd_valid
    new_run(30, 8'($urandom), 1'b1);
    blk = $urandom;
    mx  = $urandom_range(3, 2);
    do_start(blk, 16'(mx));
    wait_done("s2", 12000);
    check("s2_nreq", 32'(rd_log.size()), 32'(mx));
    for (int i = 0; i < mx; i++) check("s2_addr", log_at(i), blk + 32'(i));
    check("s2_bytes", 32'(n_bytes), 32'(BLK_BYTES * mx));
    check("s2_blk_count", 32'(blk_count), 32'(mx));
    check("s2_done_cnt", 32'(done_cnt), 32'd1);
    check("s2_fin_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));

    // Unlimited scan, stop during FILL of the fourth block
    new_run(20, 8'($urandom), 1'b1);
    blk = $urandom;
    do_start(blk, 16'd0);
    n = 0;
    while (rd_log.size() < 4 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("s3_reached_blk4", 32'(rd_log.size()), 32'd4);
    repeat (20) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("s3", 4000);
    check("s3_blk_count", 32'(blk_count), 32'd4);
    check("s3_bytes", 32'(n_bytes), 32'd2048);
    check("s3_fin_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
    check("s3_done_cnt", 32'(done_cnt), 32'd1);
    repeat (50) @(negedge clk);
    check("s3_no_more_req", 32'(rd_log.size()), 32'd4);

    // SD source dies after 100 bytes -> timeout
    new_run(0, 8'h00, 1'b0);
    sd_limit = 100;
    do_start(32'h0000_5000, 16'd0);
    wait_done("s4", 4000);
    check("s4_err", 32'(err), 32'd1);
    check("s4_timeout_gap", 32'(done_cyc - last_valid_cyc), 32'(TMO));
    check("s4_bytes", 32'(n_bytes), 32'd0);
    check("s4_blk_count", 32'(blk_count), 32'd0);
    repeat (10) @(negedge clk);
    check("s4_err_sticky", 32'(err), 32'd1);

    // Stop while idle, start before init, start while busy, address wrap
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    new_run(10, 8'($urandom), 1'b1);
    init_finished = 1'b0;
    do_start(32'h1111_0000, 16'd1);
    repeat (5) @(negedge clk);
    check("s5_no_init_busy", 32'(busy), 32'd0);
    check("s5_no_init_req", 32'(rd_log.size()), 32'd0);
    init_finished = 1'b1;
    do_start(32'hFFFF_FFFF, 16'd2);
    repeat (30) @(negedge clk);
    do_start(32'h0000_ABCD, 16'd9);
    wait_done("s5", 8000);
    check("s5_nreq", 32'(rd_log.size()), 32'd2);
    check("s5_addr0", log_at(0), 32'hFFFF_FFFF);
    check("s5_addr1_wrap", log_at(1), 32'h0000_0000);
    check("s5_blk_count", 32'(blk_count), 32'd2);
    check("s5_err_cleared", 32'(err), 32'd0);
    check("s5_bytes", 32'(n_bytes), 32'd1024);
    check("s5_done_cnt", 32'(done_cnt), 32'd1);

    // Reset during DRAIN, then a clean new scan
    new_run(10, 8'($urandom), 1'b1);
    blk = $urandom;
    do_start(blk, 16'd0);
    n = 0;
    while (!bus.byte_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("s6_reached_drain", 32'(bus.byte_valid), 32'd1);
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("s6_reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("s6_no_req_after_reset", 32'(rd_log.size()), 32'd1);
    check("s6_idle_after_reset", 32'(busy), 32'd0);
    new_run(0, 8'($urandom), 1'b1);
    blk2 = $urandom;
    do_start(blk2, 16'd1);
    wait_done("s6", 4000);
    check("s6_nreq", 32'(rd_log.size()), 32'd1);
    check("s6_addr", log_at(0), blk2);
    check("s6_bytes", 32'(n_bytes), 32'd512);
    check("s6_blk_count", 32'(blk_count), 32'd1);
    check("s6_done_cnt", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
